// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter sharing one L2 port between the L1 I-cache and L1 D-cache.
// One full line transaction at a time; a granted side keeps the port until l2_resp.
module l1_l2_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises its request and holds address/wdata stable;
  // the arbiter answers with a one-cycle x_resp coincident with l2_resp, and the
  // requester drops its request the cycle after. Grants are never preempted.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state, state_next;
  logic   last_grant;  // 0 = I, 1 = D
  logic   i_req, d_req;

  assign i_req     = i_read;
  assign d_req     = d_read | d_write;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next != IDLE)
        last_grant <= (state_next == SERVE_D);
    end
  end

  always_comb begin
    state_next = state;
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_address = '0;
    l2_wdata   = '0;
    i_resp     = 1'b0;
    i_rdata    = '0;
    d_resp     = 1'b0;
    d_rdata    = '0;
    case (state)
      IDLE: begin
        // l2_resp is deliberately ignored here; spurious completions do nothing.
        if (i_req && d_req)
          state_next = last_grant ? SERVE_I : SERVE_D;
        else if (i_req)
          state_next = SERVE_I;
        else if (d_req)
          state_next = SERVE_D;
      end
      SERVE_I: begin
        l2_read    = 1'b1;
        l2_address = i_address;
        if (l2_resp) begin
          i_resp     = 1'b1;
          i_rdata    = l2_rdata;
          state_next = IDLE;
        end
      end
      SERVE_D: begin
        // Read and write together is a protocol error; the write takes priority.
        l2_read    = d_read & ~d_write;
        l2_write   = d_write;
        l2_address = d_address;
        l2_wdata   = d_wdata;
        if (l2_resp) begin
          d_resp     = 1'b1;
          d_rdata    = l2_rdata;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
